// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and a small op-classification helper.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } mdu_state_t;

  // Signed ops work on magnitudes and fix the sign up at the end.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes at accept time and to restore result signs in FIXUP.
module mul_div_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with private HI/LO registers.
// MUL is radix-2 shift-add, DIV is restoring; both take DATA_WIDTH
// iteration edges plus one FIXUP edge that commits HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_MduStart,
  input  logic                  EX_Flush,
  input  logic [2:0]            EX_MduOp,
  input  logic [DATA_WIDTH-1:0] EX_OpA,
  input  logic [DATA_WIDTH-1:0] EX_OpB,
  output logic                  Mdu_Busy,
  output logic                  Mdu_Done,
  output logic [DATA_WIDTH-1:0] Mdu_Hi,
  output logic [DATA_WIDTH-1:0] Mdu_Lo
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  mdu_state_t      r_state;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  // Operand / accumulator datapath (no reset needed, only meaningful when busy)
  logic [2*DW-1:0] r_acc;
  logic [DW-1:0]   r_opnd;
  logic [DW-1:0]   r_orig_a;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_is_div;
  logic            r_div0;

  logic            w_accept;
  logic            w_signed;
  logic            w_op_div;
  logic            w_op_mul;
  logic [DW-1:0]   w_abs_a;
  logic [DW-1:0]   w_abs_b;
  logic [DW:0]     w_mul_sum;
  logic [2*DW-1:0] w_mul_next;
  logic [DW:0]     w_rem_sh;
  logic            w_ge;
  logic [DW-1:0]   w_rem_sub;
  logic [DW-1:0]   w_rem_new;
  logic [2*DW-1:0] w_div_next;
  logic [2*DW-1:0] w_prod_fix;
  logic [DW-1:0]   w_quo_fix;
  logic [DW-1:0]   w_rem_fix;

  assign w_accept = EX_MduStart & ~EX_Flush & (r_state == ST_IDLE);
  assign w_signed = op_is_signed(EX_MduOp);
  assign w_op_div = (EX_MduOp == MDU_DIV) || (EX_MduOp == MDU_DIVU);
  assign w_op_mul = (EX_MduOp == MDU_MULT) || (EX_MduOp == MDU_MULTU);

  mul_div_unit_sign_fix #(.WIDTH(DW)) u_abs_a (
    .i_val(EX_OpA), .i_neg(w_signed & EX_OpA[DW-1]), .o_val(w_abs_a));
  mul_div_unit_sign_fix #(.WIDTH(DW)) u_abs_b (
    .i_val(EX_OpB), .i_neg(w_signed & EX_OpB[DW-1]), .o_val(w_abs_b));

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, (r_acc[0] ? r_opnd : {DW{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[DW-1:1]};

  // Restoring step: acc = {remainder, remaining dividend bits / quotient bits}.
  // The subtraction result is below the divisor, so DW bits suffice.
  assign w_rem_sh   = {r_acc[2*DW-1:DW], r_acc[DW-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_rem_sub  = w_rem_sh[DW-1:0] - r_opnd;
  assign w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[DW-1:0];
  assign w_div_next = {w_rem_new, r_acc[DW-2:0], w_ge};

  mul_div_unit_sign_fix #(.WIDTH(2*DW)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_prod_fix));
  mul_div_unit_sign_fix #(.WIDTH(DW)) u_fix_quo (
    .i_val(r_acc[DW-1:0]), .i_neg(r_sign_a ^ r_sign_b), .o_val(w_quo_fix));
  mul_div_unit_sign_fix #(.WIDTH(DW)) u_fix_rem (
    .i_val(r_acc[2*DW-1:DW]), .i_neg(r_sign_a), .o_val(w_rem_fix));

  // Operand capture on accept, then one accumulator step per iteration edge
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sign_a <= w_signed & EX_OpA[DW-1];
      r_sign_b <= w_signed & EX_OpB[DW-1];
      r_orig_a <= EX_OpA;
      r_div0   <= (EX_OpB == {DW{1'b0}});
      r_is_div <= w_op_div;
      if (w_op_div) begin
        r_opnd <= w_abs_b;
        r_acc  <= {{DW{1'b0}}, w_abs_a};
      end else begin
        r_opnd <= w_abs_a;
        r_acc  <= {{DW{1'b0}}, w_abs_b};
      end
    end else if (r_state == ST_MUL) begin
      r_acc <= w_mul_next;
    end else if (r_state == ST_DIV) begin
      r_acc <= w_div_next;
    end
  end

  // Control FSM with HI/LO commit and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            if (w_op_mul)                    r_state <= ST_MUL;
            else if (w_op_div)               r_state <= ST_DIV;
            else if (EX_MduOp == MDU_MTHI)   r_hi    <= EX_OpA;
            else if (EX_MduOp == MDU_MTLO)   r_lo    <= EX_OpA;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_count == LAST_ITER) begin
            r_count <= '0;
            r_state <= ST_FIXUP;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_FIXUP: begin
          if (r_is_div) begin
            if (r_div0) begin
              r_hi <= r_orig_a;
              r_lo <= {DW{1'b1}};
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*DW-1:DW];
            r_lo <= w_prod_fix[DW-1:0];
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Mdu_Busy = (r_state != ST_IDLE);
  assign Mdu_Done = r_done;
  assign Mdu_Hi   = r_hi;
  assign Mdu_Lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus random
// MUL/DIV traffic checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_MduStart;
  logic        EX_Flush;
  logic [2:0]  EX_MduOp;
  logic [31:0] EX_OpA;
  logic [31:0] EX_OpB;
  logic        Mdu_Busy;
  logic        Mdu_Done;
  logic [31:0] Mdu_Hi;
  logic [31:0] Mdu_Lo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  logic        prev_done = 1'b0;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .EX_MduStart(EX_MduStart), .EX_Flush(EX_Flush),
    .EX_MduOp(EX_MduOp), .EX_OpA(EX_OpA), .EX_OpB(EX_OpB),
    .Mdu_Busy(Mdu_Busy), .Mdu_Done(Mdu_Done), .Mdu_Hi(Mdu_Hi), .Mdu_Lo(Mdu_Lo));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: {HI, LO} from MIPS semantics using 64-bit arithmetic
  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin q = sa * sb; return q; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; return p; end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Monitor: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (Mdu_Done) begin
      if (prev_done) chk("done_pulse_width", 64'd2, 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        chk("result_hilo", {Mdu_Hi, Mdu_Lo}, exp_q.pop_front());
      end
    end
    prev_done = Mdu_Done;
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude);
    logic [63:0] e;
    int n;
    e = ref_mdu(op, a, b);
    @(negedge clk);
    EX_MduStart = 1'b1; EX_MduOp = op; EX_OpA = a; EX_OpB = b; EX_Flush = 1'b0;
    @(posedge clk); #1;
    EX_MduStart = 1'b0;
    exp_q.push_back(e);
    n = 0;
    while (Mdu_Busy && n < 100) begin
      if (intrude && n == 5) begin
        EX_MduStart = 1'b1; EX_MduOp = OP_MTHI; EX_OpA = 32'hDEAD0000;
      end else if (intrude && n == 8) begin
        EX_MduStart = 1'b1; EX_MduOp = OP_MULT; EX_OpA = 32'h11; EX_OpB = 32'h22;
      end else begin
        EX_MduStart = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n == 16) chk("midop_hold", {Mdu_Hi, Mdu_Lo}, {m_hi, m_lo});
    end
    EX_MduStart = 1'b0;
    chk("busy_cycles", 64'(n), 64'd33);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    EX_MduStart = 1'b1; EX_MduOp = op; EX_OpA = a; EX_OpB = 32'h0; EX_Flush = 1'b0;
    @(posedge clk); #1;
    EX_MduStart = 1'b0;
    if (op == OP_MTHI) m_hi = a; else m_lo = a;
    chk("mt_busy", {63'd0, Mdu_Busy}, 64'd0);
    chk("mt_hilo", {Mdu_Hi, Mdu_Lo}, {m_hi, m_lo});
    @(posedge clk); #1;
    chk("mt_busy_done_after", {62'd0, Mdu_Busy, Mdu_Done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; EX_MduStart = 1'b0; EX_Flush = 1'b0;
    EX_MduOp = 3'd0; EX_OpA = '0; EX_OpB = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {62'd0, Mdu_Busy, Mdu_Done}, 64'd0);
    chk("reset_hilo", {Mdu_Hi, Mdu_Lo}, 64'd0);
    reset = 1'b0;

    // Directed cases
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd7, 1'b0);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);
    do_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
    do_op(OP_DIV,   32'h00001234, 32'd0, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(OP_DIVU,  32'h89ABCDEF, 32'd0, 1'b0);
    do_mt(OP_MTLO, 32'h0000CAFE);
    do_mt(OP_MTHI, 32'h0BADF00D);
    do_op(OP_MULT,  32'h00012345, 32'hFFFF8000, 1'b1);

    // Flushed start must be ignored
    @(negedge clk);
    EX_MduStart = 1'b1; EX_Flush = 1'b1; EX_MduOp = OP_MULT;
    EX_OpA = 32'd3; EX_OpB = 32'd5;
    @(posedge clk); #1;
    EX_MduStart = 1'b0; EX_Flush = 1'b0;
    chk("flush_busy", {63'd0, Mdu_Busy}, 64'd0);
    chk("flush_hilo", {Mdu_Hi, Mdu_Lo}, {m_hi, m_lo});

    // Reset sampled at E10 of a DIVU discards it
    @(negedge clk);
    EX_MduStart = 1'b1; EX_MduOp = OP_DIVU; EX_OpA = 32'hFFFF0000; EX_OpB = 32'd3;
    @(posedge clk); #1;
    EX_MduStart = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("midreset_state", {62'd0, Mdu_Busy, Mdu_Done}, 64'd0);
    chk("midreset_hilo", {Mdu_Hi, Mdu_Lo}, 64'd0);
    do_op(OP_MULTU, 32'd6, 32'd7, 1'b0);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        default: ;
      endcase
      do_op(op, a, b, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
